// File: rtl/enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | enc_pkg : shared types and helpers for the req_encoder slice          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package enc_pkg;

  localparam int N_DEFAULT = 4;
  localparam int ONEHOT_W  = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [4:0] idx);
    logic [ONEHOT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/req_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | req_encoder_if : request/grant bus between sources and req_encoder    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface req_encoder_if #(
  parameter int N = enc_pkg::N_DEFAULT
);
  localparam int W = $clog2(N);

  logic [N-1:0] Din;
  logic         Enable;
  logic [W-1:0] Dout;
  logic         valid;
  logic         ready;
  logic [N-1:0] pending;

  modport master (
    output Din, Enable, ready,
    input  Dout, valid, pending
  );

  modport slave (
    input  Din, Enable, ready,
    output Dout, valid, pending
  );
endinterface
`default_nettype wire

// File: rtl/prio_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prio_pick : find-first-set over N bits, searching upward from start   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module prio_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from farthest to nearest so the closest set bit to start wins;
  // W-bit index arithmetic wraps N-1 -> 0 because N is a power of two.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[start + W'(k)]) begin
        idx = start + W'(k);
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/req_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | req_encoder : pending-request capture and valid/ready index encoder   |
// | Optional: ROUND_ROBIN_EN selects rotating priority (default: fixed)   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module req_encoder
  import enc_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  req_encoder_if.slave bus
);

  localparam int W = $clog2(N);

  state_t       r_state;
  state_t       w_next;
  logic [N-1:0] r_pend;
  logic [N-1:0] w_held;
  logic [N-1:0] w_mask;
  logic [N-1:0] w_clr;
  logic [W-1:0] r_dout;
  logic [W-1:0] w_idx;
  logic [W-1:0] w_start;
  logic         w_any;
  logic         w_load;
  logic         w_valid;

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_load) begin
      r_ptr <= w_idx + W'(1);
    end
  end

  assign w_start = r_ptr;
`else
  assign w_start = '0;
`endif

  // The index being held is excluded so a re-request of it waits a turn.
  assign w_held = (r_state == HOLD) ? N'(onehot(5'(r_dout))) : '0;
  assign w_mask = r_pend & ~w_held;

  prio_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req   (w_mask),
    .start (w_start),
    .idx   (w_idx),
    .any   (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_any) w_next = HOLD;
      HOLD: if (bus.ready && !w_any) w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      IDLE: w_load = w_any;
      HOLD: begin
        w_valid = 1'b1;
        w_load  = bus.ready & w_any;
      end
    endcase
  end

  assign w_clr = w_load ? N'(onehot(5'(w_idx))) : '0;

  // Set is applied after clear, so a same-cycle re-request survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_dout <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | (bus.Din & {N{bus.Enable}});
      if (w_load) begin
        r_dout <= w_idx;
      end
    end
  end

  assign bus.Dout    = r_dout;
  assign bus.valid   = w_valid;
  assign bus.pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_req_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_req_encoder : directed and randomized checks of req_encoder        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_req_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  req_encoder_if #(.N(N)) bus ();

  req_encoder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Reference: set of pending indices plus "which index is on offer, if any".
  logic [N-1:0] m_pend;
  bit           m_hold;
  int           m_idx;
  int           m_ptr;

  task automatic model_reset();
    m_pend = '0;
    m_hold = 0;
    m_idx  = 0;
    m_ptr  = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] din, input logic en, input logic rdy);
    logic [N-1:0] avail;
    int g;
    int start;
    avail = m_pend;
    if (m_hold) avail[m_idx] = 1'b0;
    g     = -1;
    start = 0;
`ifdef ROUND_ROBIN_EN
    start = m_ptr;
`endif
    if (!m_hold || rdy) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && avail[(start + k) % N]) g = (start + k) % N;
      end
    end
    if (g >= 0) m_pend[g] = 1'b0;
    if (en) m_pend = m_pend | din;
    if (g >= 0) begin
      m_hold = 1;
      m_idx  = g;
      m_ptr  = (g + 1) % N;
    end else if (m_hold && rdy) begin
      m_hold = 0;
    end
  endtask

  task automatic step(input logic [N-1:0] din, input logic en, input logic rdy);
    bus.Din    = din;
    bus.Enable = en;
    bus.ready  = rdy;
    @(posedge clk);
    model_edge(din, en, rdy);
    #1;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    bus.Din    = '0;
    bus.Enable = 1'b0;
    bus.ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (bus.valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b expected 0", bus.valid);
    end
    n_cmp++;
    if (bus.Dout !== '0) begin
      n_err++; $display("FAIL reset_dout: got %0d expected 0", bus.Dout);
    end
    n_cmp++;
    if (bus.pending !== '0) begin
      n_err++; $display("FAIL reset_pending: got %b expected 0000", bus.pending);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    n_cmp++;
    if (bus.valid !== 1'b1 || bus.Dout !== 2'd3) begin
      n_err++; $display("FAIL async_pre_hold: got valid=%b dout=%0d expected valid=1 dout=3", bus.valid, bus.Dout);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.Dout !== '0 || bus.pending !== '0) begin
      n_err++;
      $display("FAIL async_reset: got valid=%b dout=%0d pending=%b expected 0/0/0000",
               bus.valid, bus.Dout, bus.pending);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step('0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.pending !== '0) begin
      n_err++; $display("FAIL async_after: got valid=%b pending=%b expected 0/0000", bus.valid, bus.pending);
    end
  endtask

  task automatic test_enable_off();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 1'b1);
      n_cmp++;
      if (bus.pending !== '0) begin
        n_err++; $display("FAIL enable_off_pending[%0d]: got %b expected 0000", i, bus.pending);
      end
      n_cmp++;
      if (bus.valid !== 1'b0) begin
        n_err++; $display("FAIL enable_off_valid[%0d]: got %b expected 0", i, bus.valid);
      end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] din_t [3] = '{4'b0100, 4'b0000, 4'b0000};
    logic         ev    [3] = '{1'b0, 1'b1, 1'b0};
    logic [N-1:0] ep    [3] = '{4'b0100, 4'b0000, 4'b0000};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step(din_t[i], 1'b1, 1'b1);
      n_cmp++;
      if (bus.valid !== ev[i]) begin
        n_err++; $display("FAIL single_valid[%0d]: got %b expected %b", i, bus.valid, ev[i]);
      end
      if (ev[i]) begin
        n_cmp++;
        if (bus.Dout !== 2'd2) begin
          n_err++; $display("FAIL single_dout[%0d]: got %0d expected 2", i, bus.Dout);
        end
      end
      n_cmp++;
      if (bus.pending !== ep[i]) begin
        n_err++; $display("FAIL single_pending[%0d]: got %b expected %b", i, bus.pending, ep[i]);
      end
    end
  endtask

  task automatic test_priority();
    logic [N-1:0] din_t [5] = '{4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic         ev    [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] ed    [5] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd0};
    logic [N-1:0] ep    [5] = '{4'b1011, 4'b1010, 4'b1000, 4'b0000, 4'b0000};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(din_t[i], 1'b1, 1'b1);
      n_cmp++;
      if (bus.valid !== ev[i] || (ev[i] && bus.Dout !== ed[i])) begin
        n_err++;
        $display("FAIL priority[%0d]: got valid=%b dout=%0d expected valid=%b dout=%0d",
                 i, bus.valid, bus.Dout, ev[i], ed[i]);
      end
      n_cmp++;
      if (bus.pending !== ep[i]) begin
        n_err++; $display("FAIL priority_pending[%0d]: got %b expected %b", i, bus.pending, ep[i]);
      end
    end
  endtask

  task automatic test_full();
    apply_reset();
    step(4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin
      step('0, 1'b0, 1'b1);
      n_cmp++;
      if (bus.valid !== 1'b1 || bus.Dout !== W'(i)) begin
        n_err++; $display("FAIL full[%0d]: got valid=%b dout=%0d expected valid=1 dout=%0d", i, bus.valid, bus.Dout, i);
      end
    end
    step('0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.pending !== '0) begin
      n_err++; $display("FAIL full_empty: got valid=%b pending=%b expected 0/0000", bus.valid, bus.pending);
    end
  endtask

  task automatic test_requeue();
    logic [N-1:0] din_t [7] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic         rdy   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic         ev    [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [N-1:0] ep    [7] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      step(din_t[i], 1'b1, rdy[i]);
      n_cmp++;
      if (bus.valid !== ev[i] || (ev[i] && bus.Dout !== 2'd1)) begin
        n_err++;
        $display("FAIL requeue[%0d]: got valid=%b dout=%0d expected valid=%b dout=1", i, bus.valid, bus.Dout, ev[i]);
      end
      n_cmp++;
      if (bus.pending !== ep[i]) begin
        n_err++; $display("FAIL requeue_pending[%0d]: got %b expected %b", i, bus.pending, ep[i]);
      end
    end
  endtask

  task automatic test_alternate();
    apply_reset();
    step(4'b0011, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b0011, 1'b1, 1'b1);
      n_cmp++;
      if (bus.valid !== 1'b1 || bus.Dout !== W'(i % 2)) begin
        n_err++;
        $display("FAIL alternate[%0d]: got valid=%b dout=%0d expected valid=1 dout=%0d", i, bus.valid, bus.Dout, i % 2);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] din;
    logic         en;
    logic         rdy;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      din = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      en  = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      step(din, en, rdy);
      n_cmp++;
      if (bus.valid !== m_hold) begin
        n_err++; $display("FAIL random_valid[%0d]: got %b expected %b", i, bus.valid, m_hold);
      end
      if (m_hold) begin
        n_cmp++;
        if (bus.Dout !== W'(m_idx)) begin
          n_err++; $display("FAIL random_dout[%0d]: got %0d expected %0d", i, bus.Dout, m_idx);
        end
      end
      n_cmp++;
      if (bus.pending !== m_pend) begin
        n_err++; $display("FAIL random_pending[%0d]: got %b expected %b", i, bus.pending, m_pend);
      end
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus.Din    = '0;
    bus.Enable = 1'b0;
    bus.ready  = 1'b0;
    model_reset();
    test_reset();
    test_async_reset();
    test_enable_off();
    test_single();
    test_priority();
    test_full();
    test_requeue();
    test_alternate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
